score_display_driver: RTL and testbench
=======================================

// Module: score_display_driver
// PURPOSE
// - Downstream consumer of the game FSM's score: converts the binary score to three BCD digits
//   and drives three DE-board seven-segment displays (HEX2 = hundreds, HEX1 = tens, HEX0 = units).
// - Uses a sequential shift-add-3 (double-dabble) conversion, one bit per clock.
// - Samples the score once per frame_tik from game_delay, so the displays change only at frame
//   boundaries.
// PARAMETERS
// - SCORE_BIT   8   Width of score. Supported range is 1..9, so the maximum value is 511 and
//                   three digits always suffice.
// PORTS
// - clock_25  in   1          25 MHz system clock; all registers on the rising edge.
// - reset     in   1          Asynchronous, active-low reset (driven from KEY0).
// - score     in   SCORE_BIT  Binary score from snake_game_fsm.
// - frame_tik in   1          One-cycle pulse per frame; the score is sampled only on this pulse.
// - busy      out  1          High while a conversion is in progress.
// - bcd       out  12         {hundreds, tens, units} BCD; registered.
// - HEX2      out  7          Hundreds digit, active-low segments, bit order [6:0] = g..a.
// - HEX1      out  7          Tens digit, same encoding as HEX2.
// - HEX0      out  7          Units digit, same encoding as HEX2.
// BEHAVIOUR
// - Reset (async, reset=0):
//   - state=IDLE, busy=0, bcd=12'h000, last_score=0, shift/step counter=0.
//   - HEX0=7'h40 ('0'). HEX1 and HEX2 take their reset value per CONFIGURATION.
// - Segment encoding (active-low, [6:0] = g..a):
//   - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//   - Nibble values >9 are unreachable; if one occurs, drive 7'h7F (blank).
// - FSM states: IDLE, CONV, DONE.
// - IDLE:
//   - On frame_tik=1 with score != last_score, latch score, clear the BCD accumulator, set busy=1,
//     go to CONV.
//   - On frame_tik=1 with score == last_score, do nothing.
// - CONV:
//   - Each cycle, for each BCD nibble >= 5, add 3.
//   - Then shift {bcd_acc, bin} left by 1 and increment the step counter.
//   - After exactly SCORE_BIT steps, go to DONE.
// - DONE (one cycle):
//   - bcd <= bcd_acc; HEX0..HEX2 <= decoded digits; last_score <= latched score.
//   - busy <= 0; go to IDLE.
// - Latency: for a frame_tik sampled at edge N, busy is high from edge N to edge N+SCORE_BIT+1
//   (SCORE_BIT+1 cycles). bcd and HEX update on edge N+SCORE_BIT+1 (9 cycles for SCORE_BIT=8).
// - Outputs hold their previous value for the whole conversion. They never show partial results.
// - Events during a conversion:
//   - frame_tik and score changes during CONV/DONE are ignored; no request is queued.
//   - A new value is picked up at the first frame_tik in IDLE whose score differs from last_score.
// - Score at reset: score=0 right after reset needs no conversion, because the reset display
//   already shows 0.
// - Reset mid-conversion aborts immediately; all outputs return to their reset values.
// - Width: the BCD accumulator is 12 bits, with no overflow for SCORE_BIT <= 9.
// CONFIGURATION
// - Macro SCORE_LEADING_ZERO_BLANK_EN.
// - Defined:
//   - HEX2=7'h7F when hundreds==0.
//   - HEX1=7'h7F when hundreds==0 and tens==0.
//   - HEX0 is never blanked.
//   - Reset values: HEX2=HEX1=7'h7F.
// - Undefined:
//   - All three digits are always shown, including leading zeros.
//   - Reset values: HEX2=HEX1=7'h40.
// - bcd and busy are identical in both builds.
// TESTING
// - Reset:
//   - Assert reset=0 -> busy=0, bcd=12'h000, HEX0=7'h40.
//   - HEX1/HEX2=7'h40 without the macro, 7'h7F with it.
// - Full-scale: score=8'd255, one frame_tik pulse:
//   - busy is high for 9 cycles.
//   - Then bcd=12'h255, HEX2=7'h24, HEX1=7'h12, HEX0=7'h12.
// - Small value: score=8'd7 plus frame_tik:
//   - bcd=12'h007, HEX0=7'h78.
//   - HEX1/HEX2=7'h40 without the macro, 7'h7F with it.
// - Change while busy: score=100 plus frame_tik; at cycle 3 set score=42 and pulse frame_tik:
//   - Result is bcd=12'h100.
//   - The next frame_tik in IDLE gives bcd=12'h042 (HEX1=7'h19, HEX0=7'h24).
// - No change: after converting 255, pulse frame_tik with score=255:
//   - busy stays 0; bcd and HEX are unchanged.
// - Abort: assert reset=0 at cycle 4 of a 255 conversion:
//   - Outputs take reset values asynchronously.
//   - After release, score=128 plus frame_tik gives bcd=12'h128.

Source files
------------

// File: rtl/score_display_driver_if.sv
// score_display_driver_if: score request and display outputs of the score display driver.
//   master modport (score producer / bench): drives score, frame_tik; observes busy, bcd, HEX2..HEX0
//   slave  modport (score_display_driver):   samples score, frame_tik; drives busy, bcd, HEX2..HEX0
//   score     SCORE_BIT  binary score
//   frame_tik 1          one-cycle frame pulse; the score is sampled only on this pulse
//   busy      1          conversion in progress
//   bcd       12         {hundreds, tens, units}
//   HEX2..0   7          active-low segments, [6:0] = g..a
interface score_display_driver_if #(parameter int SCORE_BIT = 8);
    logic [SCORE_BIT-1:0] score;
    logic                 frame_tik;
    logic                 busy;
    logic [11:0]          bcd;
    logic [6:0]           HEX2;
    logic [6:0]           HEX1;
    logic [6:0]           HEX0;
    modport master (output score, frame_tik, input busy, bcd, HEX2, HEX1, HEX0);
    modport slave  (input score, frame_tik, output busy, bcd, HEX2, HEX1, HEX0);
endinterface

// File: rtl/score_display_driver.sv
// score_display_driver: binary score -> 3 BCD digits (sequential double-dabble) -> 7-seg displays.
//   clock_25  in   25 MHz clock, rising edge
//   reset     in   asynchronous active-low reset
//   io        slave modport of score_display_driver_if (score, frame_tik, busy, bcd, HEX2..HEX0)
// Optional build macro SCORE_LEADING_ZERO_BLANK_EN blanks leading-zero digits on HEX2/HEX1.
module score_display_driver #(
    parameter int SCORE_BIT = 8
) (
    input logic                   clock_25,
    input logic                   reset,
    score_display_driver_if.slave io
);
    localparam int SW = $clog2(SCORE_BIT + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(SCORE_BIT - 1);
    localparam logic [6:0] SEG_ZERO = 7'h40;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_RST = 7'h7F;
`else
    localparam logic [6:0] LEAD_RST = 7'h40;
`endif

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state;
    logic [SCORE_BIT-1:0] sample;
    logic [SCORE_BIT-1:0] bin;
    logic [SCORE_BIT-1:0] last_score;
    logic [11:0]          acc;
    logic [11:0]          acc_adj;
    logic [SW-1:0]        step;
    logic [6:0]           hex1_n;
    logic [6:0]           hex2_n;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign acc_adj = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};

    always_comb begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        hex2_n = (acc[11:8] == 4'd0) ? 7'h7F : seg(acc[11:8]);
        hex1_n = (acc[11:4] == 8'd0) ? 7'h7F : seg(acc[7:4]);
`else
        hex2_n = seg(acc[11:8]);
        hex1_n = seg(acc[7:4]);
`endif
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            io.busy    <= 1'b0;
            io.bcd     <= 12'h000;
            io.HEX0    <= SEG_ZERO;
            io.HEX1    <= LEAD_RST;
            io.HEX2    <= LEAD_RST;
            last_score <= '0;
            sample     <= '0;
            bin        <= '0;
            acc        <= '0;
            step       <= '0;
        end else begin
            case (state)
                IDLE: if (io.frame_tik && io.score != last_score) begin
                    sample  <= io.score;
                    bin     <= io.score;
                    acc     <= '0;
                    step    <= '0;
                    io.busy <= 1'b1;
                    state   <= CONV;
                end
                CONV: begin
                    // adjust-then-shift: the MSB of the binary operand enters the units nibble
                    acc   <= {acc_adj[10:0], bin[SCORE_BIT-1]};
                    bin   <= bin << 1;
                    step  <= step + 1'b1;
                    state <= (step == STEP_LAST) ? DONE : CONV;
                end
                DONE: begin
                    io.bcd     <= acc;
                    io.HEX0    <= seg(acc[3:0]);
                    io.HEX1    <= hex1_n;
                    io.HEX2    <= hex2_n;
                    last_score <= sample;
                    io.busy    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver: directed stimulus, behavioural display model checked every cycle,
// plus hand-computed literal expectations.
module tb_score_display_driver;
    localparam int SB = 8;

    logic clock_25 = 1'b0;
    logic reset = 1'b0;
    int n_pass = 0;
    int n_total = 0;

    score_display_driver_if #(.SCORE_BIT(SB)) io ();

    score_display_driver #(.SCORE_BIT(SB)) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .io       (io.slave)
    );

    always #20 clock_25 = ~clock_25;

    // model: a request takes SB+1 cycles, then the shown value becomes the requested score
    int m_rem = 0;
    int m_shown = 0;
    int m_pend = 0;

    always @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            m_rem = 0;
            m_shown = 0;
            m_pend = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_shown = m_pend;
        end else if (io.frame_tik && int'(io.score) != m_shown) begin
            m_pend = int'(io.score);
            m_rem = SB + 1;
        end
    end

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    function automatic logic [11:0] bcd_of(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] hex_of(input int v, input int pos);
        int d;
        d = (pos == 2) ? v / 100 : (pos == 1) ? (v / 10) % 10 : v % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (pos == 2 && v < 100) return 7'h7F;
        if (pos == 1 && v < 10) return 7'h7F;
`endif
        return seg_of(d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clock_25) begin
        check("busy", 32'(io.busy), 32'(m_rem > 0));
        check("bcd", 32'(io.bcd), 32'(bcd_of(m_shown)));
        check("HEX2", 32'(io.HEX2), 32'(hex_of(m_shown, 2)));
        check("HEX1", 32'(io.HEX1), 32'(hex_of(m_shown, 1)));
        check("HEX0", 32'(io.HEX0), 32'(hex_of(m_shown, 0)));
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD = 7'h7F;
`else
    localparam logic [6:0] LEAD = 7'h40;
`endif

    // pulse frame_tik with score s, then count busy cycles over a fixed window
    task automatic pulse_count(input int s, output int cnt);
        @(negedge clock_25);
        io.score = SB'(s);
        io.frame_tik = 1'b1;
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock_25);
            io.frame_tik = 1'b0;
            #1;
            if (io.busy) cnt++;
        end
    endtask

    initial begin
        int cnt;
        io.score = '0;
        io.frame_tik = 1'b0;
        repeat (3) @(negedge clock_25);
        #1;
        check("rst_busy", 32'(io.busy), 32'd0);
        check("rst_bcd", 32'(io.bcd), 32'h000);
        check("rst_HEX0", 32'(io.HEX0), 32'h40);
        check("rst_HEX1", 32'(io.HEX1), 32'(LEAD));
        check("rst_HEX2", 32'(io.HEX2), 32'(LEAD));
        @(negedge clock_25);
        reset = 1'b1;
        pulse_count(0, cnt);
        check("zero_after_rst_busy", 32'(cnt), 32'd0);
        pulse_count(255, cnt);
        check("full_busy_cycles", 32'(cnt), 32'd9);
        check("full_bcd", 32'(io.bcd), 32'h255);
        check("full_HEX2", 32'(io.HEX2), 32'h24);
        check("full_HEX1", 32'(io.HEX1), 32'h12);
        check("full_HEX0", 32'(io.HEX0), 32'h12);
        pulse_count(255, cnt);
        check("nochange_busy", 32'(cnt), 32'd0);
        check("nochange_bcd", 32'(io.bcd), 32'h255);
        pulse_count(7, cnt);
        check("small_bcd", 32'(io.bcd), 32'h007);
        check("small_HEX0", 32'(io.HEX0), 32'h78);
        check("small_HEX1", 32'(io.HEX1), 32'(LEAD));
        check("small_HEX2", 32'(io.HEX2), 32'(LEAD));
        @(negedge clock_25);
        io.score = SB'(100);
        io.frame_tik = 1'b1;
        @(negedge clock_25);
        io.frame_tik = 1'b0;
        repeat (2) @(negedge clock_25);
        io.score = SB'(42);
        io.frame_tik = 1'b1;
        @(negedge clock_25);
        io.frame_tik = 1'b0;
        repeat (12) @(negedge clock_25);
        #1;
        check("busy_ignore_bcd", 32'(io.bcd), 32'h100);
        pulse_count(42, cnt);
        check("after_busy_bcd", 32'(io.bcd), 32'h042);
        check("after_busy_HEX1", 32'(io.HEX1), 32'h19);
        check("after_busy_HEX0", 32'(io.HEX0), 32'h24);
        @(negedge clock_25);
        io.score = SB'(255);
        io.frame_tik = 1'b1;
        @(negedge clock_25);
        io.frame_tik = 1'b0;
        repeat (3) @(negedge clock_25);
        #5;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(io.busy), 32'd0);
        check("abort_bcd", 32'(io.bcd), 32'h000);
        check("abort_HEX0", 32'(io.HEX0), 32'h40);
        check("abort_HEX2", 32'(io.HEX2), 32'(LEAD));
        repeat (2) @(negedge clock_25);
        reset = 1'b1;
        pulse_count(128, cnt);
        check("post_abort_bcd", 32'(io.bcd), 32'h128);
        pulse_count(0, cnt);
        check("back_to_zero_bcd", 32'(io.bcd), 32'h000);
        check("back_to_zero_HEX0", 32'(io.HEX0), 32'h40);
        pulse_count(9, cnt);
        check("nine_HEX0", 32'(io.HEX0), 32'h10);
        @(negedge clock_25);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
